// File: rtl/snake_body_engine.sv
// Snake body engine: segment storage, movement/growth/collision, and a 2-stage pixel renderer.
// Optional macro WALL_KILL_EN: leaving the grid is fatal instead of wrapping around.
module snake_body_engine #(
  parameter int          MAX_LEN    = 16,
  parameter int          INIT_LEN   = 4,
  parameter int          GRID_W     = 64,
  parameter int          GRID_H     = 48,
  parameter int          COORD_W    = 6,
  parameter int          CELL_PX    = 10,
  parameter int          INIT_X     = 20,
  parameter int          INIT_Y     = 24,
  parameter logic [11:0] HEAD_COLOR = 12'h0F0,
  parameter logic [11:0] BODY_COLOR = 12'h0A0,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               tick,
  input  logic [1:0]                         dir,
  input  logic                               grow,
  input  logic [9:0]                         hcount,
  input  logic [9:0]                         vcount,
  output logic [11:0]                        color,
  output logic [COORD_W-1:0]                 head_x,
  output logic [COORD_W-1:0]                 head_y,
  output logic [$clog2(MAX_LEN+1)-1:0]       length,
  output logic                               dead
);

  localparam int LEN_W = $clog2(MAX_LEN+1);
`ifdef WALL_KILL_EN
  localparam bit WALL_KILL = 1'b1;
`else
  localparam bit WALL_KILL = 1'b0;
`endif

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  logic [COORD_W-1:0] seg_x [MAX_LEN];
  logic [COORD_W-1:0] seg_y [MAX_LEN];
  dir_t               heading;
  dir_t               hd_next;
  logic [LEN_W-1:0]   len_q;
  logic               grow_pend;
  logic               dead_q;

  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;
  logic               off_grid;
  logic               grows;
  logic               hit;
  logic               kill;

  // Next head position, computed with the heading accepted on this tick.
  always_comb begin
    hd_next  = heading;
    nx       = seg_x[0];
    ny       = seg_y[0];
    off_grid = 1'b0;
    grows    = 1'b0;
    hit      = 1'b0;
    kill     = 1'b0;
    if (dir != (heading ^ 2'd2)) hd_next = dir_t'(dir);
    case (hd_next)
      DIR_RIGHT: begin
        if (seg_x[0] == COORD_W'(GRID_W-1)) begin
          nx = '0;
          off_grid = 1'b1;
        end else nx = seg_x[0] + COORD_W'(1);
      end
      DIR_LEFT: begin
        if (seg_x[0] == '0) begin
          nx = COORD_W'(GRID_W-1);
          off_grid = 1'b1;
        end else nx = seg_x[0] - COORD_W'(1);
      end
      DIR_DOWN: begin
        if (seg_y[0] == COORD_W'(GRID_H-1)) begin
          ny = '0;
          off_grid = 1'b1;
        end else ny = seg_y[0] + COORD_W'(1);
      end
      default: begin
        if (seg_y[0] == '0) begin
          ny = COORD_W'(GRID_H-1);
          off_grid = 1'b1;
        end else ny = seg_y[0] - COORD_W'(1);
      end
    endcase
    grows = (grow_pend | grow) && (len_q < LEN_W'(MAX_LEN));
    // The tail only stays in place when the move grows the body.
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(len_q) - 1 || (grows && i == int'(len_q) - 1)) &&
          seg_x[i] == nx && seg_y[i] == ny)
        hit = 1'b1;
    end
    kill = hit | (WALL_KILL & off_grid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? COORD_W'(INIT_X - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? COORD_W'(INIT_Y) : '0;
      end
      heading   <= DIR_RIGHT;
      len_q     <= LEN_W'(INIT_LEN);
      grow_pend <= 1'b0;
      dead_q    <= 1'b0;
    end else if (!dead_q) begin
      if (grow) grow_pend <= 1'b1;
      if (tick) begin
        heading <= hd_next;
        if (kill) begin
          dead_q <= 1'b1;
        end else begin
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          if (grows) len_q <= len_q + LEN_W'(1);
          grow_pend <= 1'b0;
        end
      end
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len_q;
  assign dead   = dead_q;

  logic [9:0]  cx_q;
  logic [9:0]  cy_q;
  logic        pix_v;
  logic [11:0] pix_color;
  logic        head_hit;
  logic        body_hit;

  // pix_v masks the cleared cell coordinates for the cycle following reset.
  always_comb begin
    pix_color = BG_COLOR;
    head_hit  = (cx_q == 10'(seg_x[0])) && (cy_q == 10'(seg_y[0]));
    body_hit  = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (i < int'(len_q) && cx_q == 10'(seg_x[i]) && cy_q == 10'(seg_y[i]))
        body_hit = 1'b1;
    end
    if (pix_v && cx_q < 10'(GRID_W) && cy_q < 10'(GRID_H)) begin
      if (head_hit)      pix_color = HEAD_COLOR;
      else if (body_hit) pix_color = BODY_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cx_q  <= '0;
      cy_q  <= '0;
      pix_v <= 1'b0;
      color <= BG_COLOR;
    end else begin
      cx_q  <= hcount / 10'(CELL_PX);
      cy_q  <= vcount / 10'(CELL_PX);
      pix_v <= 1'b1;
      color <= pix_color;
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: directed scenarios plus randomized moves
// checked against a queue-based behavioural model of the snake.
module tb_snake_body_engine;

  localparam int          MAX_LEN = 16;
  localparam int          GRID_W  = 64;
  localparam int          GRID_H  = 48;
  localparam logic [11:0] HEAD_C  = 12'h0F0;
  localparam logic [11:0] BODY_C  = 12'h0A0;
  localparam logic [11:0] BG_C    = 12'h000;
`ifdef WALL_KILL_EN
  localparam bit WALL_KILL = 1'b1;
`else
  localparam bit WALL_KILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, tick, grow;
  logic [1:0]  dir;
  logic [9:0]  hcount, vcount;
  logic [11:0] color;
  logic [5:0]  head_x, head_y;
  logic [4:0]  length;
  logic        dead;

  int n_cmp  = 0;
  int n_fail = 0;

  snake_body_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .grow(grow),
    .hcount(hcount), .vcount(vcount), .color(color),
    .head_x(head_x), .head_y(head_y), .length(length), .dead(dead)
  );

  always #5 clk = ~clk;

  // Reference model: the body is a list of cells, head first.
  int sx[$];
  int sy[$];
  int hd;
  bit pend;
  bit mdead;
  logic [11:0] exp_q[$];

  function automatic void model_reset();
    sx.delete();
    sy.delete();
    for (int i = 0; i < 4; i++) begin
      sx.push_back(20 - i);
      sy.push_back(24);
    end
    hd = 0;
    pend = 1'b0;
    mdead = 1'b0;
  endfunction

  function automatic void model_edge(bit t, int d, bit g);
    int nx, ny;
    bit growing, hit, wall;
    if (mdead) return;
    if (g) pend = 1'b1;
    if (!t) return;
    if (d != (hd + 2) % 4) hd = d;
    nx = sx[0];
    ny = sy[0];
    case (hd)
      0: nx = nx + 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: ny = ny - 1;
    endcase
    wall = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
    nx = (nx + GRID_W) % GRID_W;
    ny = (ny + GRID_H) % GRID_H;
    growing = pend && (sx.size() < MAX_LEN);
    hit = wall && WALL_KILL;
    for (int i = 0; i < sx.size(); i++)
      if ((growing || i < sx.size() - 1) && sx[i] == nx && sy[i] == ny) hit = 1'b1;
    if (hit) begin
      mdead = 1'b1;
      return;
    end
    sx.push_front(nx);
    sy.push_front(ny);
    if (!growing) begin
      void'(sx.pop_back());
      void'(sy.pop_back());
    end
    pend = 1'b0;
  endfunction

  function automatic logic [11:0] model_color(int h, int v);
    int cx, cy;
    cx = h / 10;
    cy = v / 10;
    if (cx >= GRID_W || cy >= GRID_H) return BG_C;
    if (cx == sx[0] && cy == sy[0]) return HEAD_C;
    for (int i = 1; i < sx.size(); i++)
      if (cx == sx[i] && cy == sy[i]) return BODY_C;
    return BG_C;
  endfunction

  function automatic logic [17:0] exp_state();
    return {6'(sx[0]), 6'(sy[0]), 5'(sx.size()), mdead};
  endfunction

  task automatic clk_step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(tick, int'(dir), grow);
    @(negedge clk);
  endtask

  task automatic move(input logic [1:0] d, input bit g, input bit t);
    dir = d;
    grow = g;
    tick = t;
    clk_step();
    tick = 1'b0;
    grow = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; grow = 1'b0; dir = 2'd0;
    hcount = '0; vcount = '0;
    repeat (3) clk_step();
    reset = 1'b0;
    n_cmp++;
    if ({head_x, head_y, length, dead} !== {6'd20, 6'd24, 5'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got x=%0d y=%0d len=%0d dead=%0d want 20 24 4 0",
               head_x, head_y, length, dead);
    end
    n_cmp++;
    if (color !== BG_C) begin
      n_fail++;
      $display("FAIL reset_color: got %h want %h", color, BG_C);
    end
    hcount = 10'd205; vcount = 10'd245;
    repeat (3) clk_step();
    n_cmp++;
    if (color !== HEAD_C) begin
      n_fail++;
      $display("FAIL pre_reset_head_pixel: got %h want %h", color, HEAD_C);
    end
    // Reset with a tick pending: reset wins, colour goes background for two cycles.
    reset = 1'b1; tick = 1'b1; dir = 2'd1;
    clk_step();
    reset = 1'b0; tick = 1'b0; dir = 2'd0;
    n_cmp++;
    if (color !== BG_C) begin
      n_fail++;
      $display("FAIL reset_color_cycle1: got %h want %h", color, BG_C);
    end
    clk_step();
    n_cmp++;
    if (color !== BG_C) begin
      n_fail++;
      $display("FAIL reset_color_cycle2: got %h want %h", color, BG_C);
    end
    clk_step();
    n_cmp++;
    if (color !== HEAD_C) begin
      n_fail++;
      $display("FAIL reset_color_cycle3: got %h want %h", color, HEAD_C);
    end
    n_cmp++;
    if ({head_x, head_y} !== {6'd20, 6'd24}) begin
      n_fail++;
      $display("FAIL reset_overrides_tick: got x=%0d y=%0d want 20 24", head_x, head_y);
    end
  endtask

  task automatic test_move();
    do_reset();
    repeat (3) move(2'd0, 1'b0, 1'b1);
    n_cmp++;
    if ({head_x, head_y, length, dead} !== {6'd23, 6'd24, 5'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL three_ticks: got x=%0d y=%0d len=%0d dead=%0d want 23 24 4 0",
               head_x, head_y, length, dead);
    end
    hcount = 10'd205; vcount = 10'd245;
    repeat (2) clk_step();
    n_cmp++;
    if (color !== BODY_C) begin
      n_fail++;
      $display("FAIL tail_at_20_24: got %h want %h", color, BODY_C);
    end
    hcount = 10'd195;
    repeat (2) clk_step();
    n_cmp++;
    if (color !== BG_C) begin
      n_fail++;
      $display("FAIL vacated_19_24: got %h want %h", color, BG_C);
    end
  endtask

  task automatic test_reverse();
    move(2'd2, 1'b0, 1'b1);
    n_cmp++;
    if ({head_x, head_y} !== {6'd24, 6'd24}) begin
      n_fail++;
      $display("FAIL reverse_ignored: got x=%0d y=%0d want 24 24", head_x, head_y);
    end
    move(2'd1, 1'b0, 1'b1);
    n_cmp++;
    if ({head_x, head_y} !== {6'd24, 6'd25}) begin
      n_fail++;
      $display("FAIL turn_down: got x=%0d y=%0d want 24 25", head_x, head_y);
    end
  endtask

  task automatic test_grow();
    do_reset();
    move(2'd0, 1'b1, 1'b0);
    repeat (2) clk_step();
    move(2'd0, 1'b0, 1'b1);
    n_cmp++;
    if (length !== 5'd5) begin
      n_fail++;
      $display("FAIL grow_deferred: got len=%0d want 5", length);
    end
    hcount = 10'd175; vcount = 10'd245;
    repeat (2) clk_step();
    n_cmp++;
    if (color !== BODY_C) begin
      n_fail++;
      $display("FAIL tail_retained_17_24: got %h want %h", color, BODY_C);
    end
    move(2'd0, 1'b1, 1'b1);
    n_cmp++;
    if (length !== 5'd6) begin
      n_fail++;
      $display("FAIL grow_same_cycle: got len=%0d want 6", length);
    end
    repeat (20) move(2'd0, 1'b1, 1'b1);
    n_cmp++;
    if (length !== 5'd16) begin
      n_fail++;
      $display("FAIL grow_saturate: got len=%0d want 16", length);
    end
    n_cmp++;
    if ({head_x, head_y, length, dead} !== exp_state()) begin
      n_fail++;
      $display("FAIL grow_model: got %h want %h", {head_x, head_y, length, dead}, exp_state());
    end
  endtask

  task automatic test_collision();
    do_reset();
    move(2'd0, 1'b1, 1'b1);
    move(2'd1, 1'b0, 1'b1);
    move(2'd2, 1'b0, 1'b1);
    move(2'd3, 1'b0, 1'b1);
    n_cmp++;
    if ({head_x, head_y, length, dead} !== {6'd20, 6'd25, 5'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL u_turn_dead: got x=%0d y=%0d len=%0d dead=%0d want 20 25 5 1",
               head_x, head_y, length, dead);
    end
    move(2'd0, 1'b1, 1'b1);
    move(2'd0, 1'b0, 1'b1);
    n_cmp++;
    if ({head_x, head_y, length, dead} !== {6'd20, 6'd25, 5'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL dead_frozen: got x=%0d y=%0d len=%0d dead=%0d want 20 25 5 1",
               head_x, head_y, length, dead);
    end
    do_reset();
    n_cmp++;
    if ({length, dead} !== {5'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL dead_cleared: got len=%0d dead=%0d want 4 0", length, dead);
    end
    // Stepping into the cell the tail is vacating is legal without growth.
    move(2'd1, 1'b0, 1'b1);
    move(2'd2, 1'b0, 1'b1);
    move(2'd3, 1'b0, 1'b1);
    n_cmp++;
    if ({head_x, head_y, dead} !== {6'd19, 6'd24, 1'b0}) begin
      n_fail++;
      $display("FAIL chase_tail: got x=%0d y=%0d dead=%0d want 19 24 0", head_x, head_y, dead);
    end
    do_reset();
    move(2'd1, 1'b0, 1'b1);
    move(2'd2, 1'b0, 1'b1);
    move(2'd3, 1'b1, 1'b1);
    n_cmp++;
    if ({head_x, head_y, length, dead} !== {6'd19, 6'd25, 5'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL chase_tail_growing: got x=%0d y=%0d len=%0d dead=%0d want 19 25 4 1",
               head_x, head_y, length, dead);
    end
  endtask

  task automatic test_wall();
    do_reset();
    repeat (43) move(2'd0, 1'b0, 1'b1);
    n_cmp++;
    if (head_x !== 6'd63) begin
      n_fail++;
      $display("FAIL reach_edge: got x=%0d want 63", head_x);
    end
    move(2'd0, 1'b0, 1'b1);
`ifdef WALL_KILL_EN
    n_cmp++;
    if ({head_x, dead} !== {6'd63, 1'b1}) begin
      n_fail++;
      $display("FAIL wall_kill: got x=%0d dead=%0d want 63 1", head_x, dead);
    end
`else
    n_cmp++;
    if ({head_x, dead} !== {6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_x: got x=%0d dead=%0d want 0 0", head_x, dead);
    end
`endif
    do_reset();
    repeat (25) move(2'd3, 1'b0, 1'b1);
    n_cmp++;
    if ({head_x, head_y, length, dead} !== exp_state()) begin
      n_fail++;
      $display("FAIL top_edge_model: got %h want %h", {head_x, head_y, length, dead}, exp_state());
    end
  endtask

  task automatic test_render();
    int hs[$];
    int vs[$];
    logic [11:0] e;
    do_reset();
    exp_q.delete();
    hs.push_back(190); vs.push_back(240);
    for (int h = 200; h <= 209; h++) begin
      hs.push_back(h);
      vs.push_back(240);
    end
    hs.push_back(700); vs.push_back(240);
    hs.push_back(205); vs.push_back(600);
    hs.push_back(185); vs.push_back(249);
    for (int i = 0; i < hs.size() + 2; i++) begin
      if (i >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (color !== e) begin
          n_fail++;
          $display("FAIL render_sweep[%0d]: got %h want %h", i - 2, color, e);
        end
      end
      if (i < hs.size()) begin
        hcount = 10'(hs[i]);
        vcount = 10'(vs[i]);
        exp_q.push_back(model_color(hs[i], vs[i]));
      end
      clk_step();
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    int idx, h, v;
    do_reset();
    for (int round = 0; round < 6; round++) begin
      for (int c = 0; c < 300; c++) begin
        dir   = 2'($urandom_range(0, 3));
        tick  = ($urandom_range(0, 2) == 0);
        grow  = ($urandom_range(0, 5) == 0);
        reset = mdead && ($urandom_range(0, 3) == 0);
        clk_step();
        tick = 1'b0; grow = 1'b0; reset = 1'b0;
        n_cmp++;
        if ({head_x, head_y, length, dead} !== exp_state()) begin
          n_fail++;
          $display("FAIL random_move r%0d c%0d: got %h want %h", round, c,
                   {head_x, head_y, length, dead}, exp_state());
        end
      end
      exp_q.delete();
      for (int i = 0; i < 82; i++) begin
        if (i >= 2) begin
          e = exp_q.pop_front();
          n_cmp++;
          if (color !== e) begin
            n_fail++;
            $display("FAIL random_pixel r%0d i%0d: got %h want %h", round, i, color, e);
          end
        end
        if (i < 80) begin
          if ($urandom_range(0, 1) == 0) begin
            idx = $urandom_range(0, sx.size() - 1);
            h = sx[idx] * 10 + $urandom_range(0, 9);
            v = sy[idx] * 10 + $urandom_range(0, 9);
          end else begin
            h = $urandom_range(0, 1023);
            v = $urandom_range(0, 1023);
          end
          hcount = 10'(h);
          vcount = 10'(v);
          exp_q.push_back(model_color(h, v));
        end
        clk_step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_reverse();
    test_grow();
    test_collision();
    test_wall();
    test_render();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake body engine: stores up to MAX_LEN grid segments, advances the body one cell per move strobe, grows on request, detects self-collision (and optionally wall collision), and renders the body into the VGA pixel stream. Sits between the game/input logic and the VGA controller, replacing fixed four-segment position wiring and the unregistered pixel-to-cell division.

## Interface
- MAX_LEN, 16: segment storage depth; length saturates here (≥ INIT_LEN ≥ 2).
- INIT_LEN, 4: length after reset.
- GRID_W, 64 / GRID_H, 48: grid size in cells.
- COORD_W, 6: width of a cell coordinate (2^COORD_W ≥ GRID_W, GRID_H).
- CELL_PX, 10: pixels per cell edge.
- INIT_X, 20 / INIT_Y, 24: head cell after reset.
- HEAD_COLOR, 12'h0F0 / BODY_COLOR, 12'h0A0 / BG_COLOR, 12'h000: 12-bit RGB (4:4:4).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- tick  in  1  move strobe, one-cycle pulse.
- dir  in  2  requested heading: 0 right, 1 down, 2 left, 3 up.
- grow  in  1  one-cycle pulse: add one segment on the next move.
- hcount  in  10  current VGA pixel column.
- vcount  in  10  current VGA pixel row.
- color  out  12  pixel color to the VGA controller.
- head_x / head_y  out  COORD_W  current head cell.
- length  out  $clog2(MAX_LEN+1)  current segment count.
- dead  out  1  sticky collision flag.

## Operation
- Storage: seg[0] = head, seg[length-1] = tail; entries ≥ length are don't-care and never drawn.
- Reset: seg[i] = (INIT_X−i, INIT_Y) for i < INIT_LEN; heading = right; length = INIT_LEN; grow_pend = 0; dead = 0; color = BG_COLOR; pipeline registers cleared.
- Heading: on tick, dir is accepted unless it is the exact reverse of the current heading, in which case the heading is unchanged.
- Move (tick=1, dead=0): new head = seg[0] + delta(heading). X wraps GRID_W−1→0 and 0→GRID_W−1; Y wraps likewise with GRID_H. All segments shift down one slot (seg[i+1] ← seg[i]).
- Growth: grow sets grow_pend. On a move with grow_pend=1, length ← min(length+1, MAX_LEN) and grow_pend clears; at MAX_LEN the move is a plain shift and grow_pend still clears.
- Collision: new head is compared with seg[0..length−2], and also with seg[length−1] when the move grows. On a match, dead ← 1 and the body is NOT updated (frozen at pre-move state). dead stays set until reset.
- tick while dead=1 is ignored, and grow while dead=1 is ignored.
- Rendering: stage 1 registers cx = hcount/CELL_PX and cy = vcount/CELL_PX. Stage 2 registers color: HEAD_COLOR if (cx,cy)==seg[0]; otherwise BODY_COLOR if it matches any seg[1..length−1]; otherwise BG_COLOR. Cells with cx ≥ GRID_W or cy ≥ GRID_H render BG_COLOR.

## Timing
- A move completes in the cycle tick is sampled. head_x/head_y/length/dead reflect the move on the following clock edge.
- grow and tick in the same cycle: the growth applies to that move.
- Pixel latency is exactly 2 clk from hcount/vcount to color. The VGA controller compensates for this by delaying its timing by 2 cycles.
- A move changes the rendered body starting from the pixel sampled in the cycle after the move edge. No frame buffering is done, so tearing mid-frame is allowed.
- reset asserted mid-move or mid-line: state returns to reset values on that edge, and color is BG_COLOR for the next 2 cycles.

## Configuration
- WALL_KILL_EN defined: a move whose new head would leave the grid (x past GRID_W−1 or below 0, y likewise) sets dead=1 and leaves the body unchanged. No wrap occurs.
- WALL_KILL_EN undefined: wrap-around as described in Operation; edges are never fatal.

## Test plan
- Reset, then 3 ticks with dir=0 (right) → head_x=23, head_y=24, length=4, dead=0; seg[3]=(20,24).
- Heading right, tick with dir=2 (left) → reverse ignored: head_x increments by 1. Then tick with dir=1 (down) → head_y=25.
- grow pulse, 2 cycles idle, then tick → length=5 with the tail retained. grow+tick in the same cycle → length=6. 20 grow+tick pairs → length saturates at 16.
- Build length 5, then move down, left, up (a U-turn into own body) → dead=1 on the closing move, head unchanged, further ticks ignored; reset → dead=0, length=4.
- Head at x=63 heading right, tick → without WALL_KILL_EN: head_x=0, dead=0. With WALL_KILL_EN: dead=1, head_x=63.
- Sweep hcount=200..209, vcount=240 with head at (20,24) → color=HEAD_COLOR exactly 2 cycles after each of those samples. hcount=190 (cell 19,24, body) → BODY_COLOR. hcount=700 → BG_COLOR.
